// File: rtl/i2s_master_codec_port_if.sv
// Bundle of the sample-stream, status and I2S pin signals of the codec port.
// The master modport is the port block itself; slave is the codec/bench side.
interface i2s_master_codec_port_if;
    logic        enable;
    logic [23:0] s_left;
    logic [23:0] s_right;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] m_left;
    logic [23:0] m_right;
    logic        m_valid;
    logic        underrun;
    logic        i2s_bclk;
    logic        i2s_lr;
    logic        i2s_d_out;
    logic        i2s_d_in;

    modport master (
        input  enable, s_left, s_right, s_valid, i2s_d_in,
        output s_ready, m_left, m_right, m_valid, underrun,
               i2s_bclk, i2s_lr, i2s_d_out
    );

    modport slave (
        output enable, s_left, s_right, s_valid, i2s_d_in,
        input  s_ready, m_left, m_right, m_valid, underrun,
               i2s_bclk, i2s_lr, i2s_d_out
    );
endinterface

// File: rtl/i2s_master_codec_port.sv
// I2S bus master: divides clk into BCLK/word select, shifts stereo 24-bit frames
// out on i2s_d_out and collects the slave's frame from i2s_d_in.
module i2s_master_codec_port #(
    parameter int CLK_DIV = 4
) (
    input logic clk,
    input logic rst,
    i2s_master_codec_port_if.master bus
);
    localparam int HW = $clog2(CLK_DIV);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

    logic [HW-1:0] half_cnt;
    logic [5:0]    bit_cnt;
    logic          bclk;
    logic          d_out;
    logic          buf_full;
    logic [47:0]   hold;
    logic [63:0]   tx_sr;
    logic [63:0]   rx_sr;
    logic [63:0]   next_frame;
    logic [23:0]   m_left_q;
    logic [23:0]   m_right_q;
    logic          m_valid_q;
    logic          underrun_q;
    logic          tick;
    logic          rise_ev;
    logic          fall_ev;
    logic          load;
    logic          accept;

    assign tick    = bus.enable && (half_cnt == HALF_LAST);
    assign rise_ev = tick && !bclk;
    assign fall_ev = tick && bclk;
    // The frame is fetched on the fall that enters bit 1 (one-bit I2S delay).
    assign load    = fall_ev && (bit_cnt == 6'd0);
    assign accept  = bus.s_valid && !buf_full;

    assign next_frame = buf_full ? {hold[47:24], 8'h00, hold[23:0], 8'h00} : 64'd0;

    // NOTE: every register here uses <= so all blocks see pre-edge values of each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt <= '0;
            bclk     <= 1'b0;
            bit_cnt  <= 6'd0;
        end else if (!bus.enable) begin
            half_cnt <= '0;
            bclk     <= 1'b0;
            bit_cnt  <= 6'd0;
        end else begin
            half_cnt <= tick ? '0 : half_cnt + 1'b1;
            if (tick)    bclk    <= !bclk;
            if (fall_ev) bit_cnt <= bit_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr <= 64'd0;
            d_out <= 1'b0;
        end else if (!bus.enable) begin
            d_out <= 1'b0;
        end else if (load) begin
            d_out <= next_frame[63];
            tx_sr <= {next_frame[62:0], 1'b0};
        end else if (fall_ev) begin
            d_out <= tx_sr[63];
            tx_sr <= {tx_sr[62:0], 1'b0};
        end
    end

    // A sample accepted on the load edge itself lands in the buffer for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= 1'b0;
            hold     <= 48'd0;
        end else if (accept) begin
            buf_full <= 1'b1;
            hold     <= {bus.s_left, bus.s_right};
        end else if (load) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sr      <= 64'd0;
            m_left_q   <= 24'd0;
            m_right_q  <= 24'd0;
            m_valid_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            m_valid_q  <= load;
            underrun_q <= load && !buf_full;
            if (!bus.enable)  rx_sr <= 64'd0;
            else if (rise_ev) rx_sr <= {rx_sr[62:0], bus.i2s_d_in};
            if (load) begin
                m_left_q  <= rx_sr[63:40];
                m_right_q <= rx_sr[31:8];
            end
        end
    end

    assign bus.i2s_bclk  = bclk;
    assign bus.i2s_lr    = bit_cnt[5];
    assign bus.i2s_d_out = d_out;
    assign bus.s_ready   = !buf_full;
    assign bus.m_left    = m_left_q;
    assign bus.m_right   = m_right_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_i2s_master_codec_port.sv
// Self-checking bench: frame-level model of the I2S master compared every cycle,
// plus directed loopback, underrun, backpressure, reset and enable scenarios.
module tb_i2s_master_codec_port;
    localparam int DIV       = 4;
    localparam int FRAME_CLK = 128 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loopback = 1'b1;
    logic slave_bit = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    i2s_master_codec_port_if bus ();

    i2s_master_codec_port #(.CLK_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.i2s_d_in = loopback ? bus.i2s_d_out : slave_bit;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Frame-level model: time since enable gives BCLK phase and bit position directly.
    int          n_en;
    bit          m_full;
    logic [23:0] m_bl, m_br;
    logic [63:0] cur_tx, cur_rx;
    bit          rx_known, m_known;
    logic        e_bclk, e_lr, e_dout, e_mv, e_ur;
    logic [23:0] e_ml, e_mr;
    int          e_bc;

    task automatic model_reset();
        n_en = 0; m_full = 0; m_bl = '0; m_br = '0;
        cur_tx = '0; cur_rx = {$urandom, $urandom};
        rx_known = 0; m_known = 1;
        e_bclk = 0; e_lr = 0; e_dout = 0; e_mv = 0; e_ur = 0;
        e_ml = '0; e_mr = '0; e_bc = 0;
    endtask

    task automatic model_step();
        bit acc, load;
        int t;
        logic [63:0] w;
        acc  = bus.s_valid && !m_full;
        load = 0;
        if (!bus.enable) begin
            n_en = 0;
            rx_known = 0;
        end else begin
            n_en++;
            load = (n_en % (2 * DIV) == 0) && ((n_en / (2 * DIV)) % 64 == 1);
        end
        e_mv = load;
        e_ur = load && !m_full;
        if (load) begin
            w = loopback ? cur_tx : cur_rx;
            if (rx_known) begin
                e_ml = w[63:40]; e_mr = w[31:8]; m_known = 1;
            end else begin
                m_known = 0;
            end
            rx_known = 1;
            cur_tx = m_full ? {m_bl, 8'h00, m_br, 8'h00} : 64'd0;
            cur_rx = {$urandom, $urandom};
            m_full = 0;
        end
        if (acc) begin
            m_bl = bus.s_left; m_br = bus.s_right; m_full = 1;
        end
        t      = n_en / DIV;
        e_bclk = t[0];
        e_bc   = (t / 2) % 64;
        e_lr   = (e_bc >= 32);
        e_dout = (e_bc == 0) ? 1'b0 : cur_tx[64 - e_bc];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Compare process plus monitors used by the directed checks.
    int          ur_cnt = 0, mv_cnt = 0, ones_cnt = 0;
    logic [47:0] mv_log[$];

    initial forever begin
        @(negedge clk);
        slave_bit = (e_bc == 0) ? cur_rx[0] : cur_rx[64 - e_bc];
        check("bclk",     64'(bus.i2s_bclk),  64'(e_bclk));
        check("lr",       64'(bus.i2s_lr),    64'(e_lr));
        check("d_out",    64'(bus.i2s_d_out), 64'(e_dout));
        check("m_valid",  64'(bus.m_valid),   64'(e_mv));
        check("underrun", 64'(bus.underrun),  64'(e_ur));
        check("s_ready",  64'(bus.s_ready),   64'(!m_full));
        if (m_known) begin
            check("m_left",  64'(bus.m_left),  64'(e_ml));
            check("m_right", 64'(bus.m_right), 64'(e_mr));
        end
        if (bus.underrun)  ur_cnt++;
        if (bus.m_valid)   begin mv_cnt++; mv_log.push_back({bus.m_left, bus.m_right}); end
        if (bus.i2s_d_out) ones_cnt++;
    end

    function automatic bit next_is_load();
        return bus.enable && ((n_en + 1) % (2 * DIV) == 0) && (((n_en + 1) / (2 * DIV)) % 64 == 1);
    endfunction

    task automatic wait_mvalid(input int bound);
        bit ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.m_valid) begin ok = 1; break; end
        end
        if (!ok) fail_timeout("wait_m_valid");
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r, input bit keep_valid);
        bit rdy, ok = 0;
        bus.s_left = l; bus.s_right = r; bus.s_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME_CLK; i++) begin
            rdy = bus.s_ready;
            @(negedge clk);
            if (rdy) begin ok = 1; break; end
        end
        if (!ok) fail_timeout("push");
        if (!keep_valid) bus.s_valid = 1'b0;
    endtask

    task automatic wait_state(input int bc);
        bit ok = 0;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            @(negedge clk);
            if (bus.enable && e_bc == bc && e_bclk) begin ok = 1; break; end
        end
        if (!ok) fail_timeout("wait_bit_cnt");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, base, k, ur0, mv0, on0, stop_at, stop_len;
        logic prev;
        logic [23:0] sl[3], sr[3];
        logic [23:0] xl, xr;

        bus.enable = 1'b0; bus.s_valid = 1'b0; bus.s_left = '0; bus.s_right = '0;
        repeat (3) @(negedge clk);
        check("rst_bclk",    64'(bus.i2s_bclk),  64'(0));
        check("rst_lr",      64'(bus.i2s_lr),    64'(0));
        check("rst_d_out",   64'(bus.i2s_d_out), 64'(0));
        check("rst_m_valid", 64'(bus.m_valid),   64'(0));
        check("rst_m_left",  64'(bus.m_left),    64'(0));
        check("rst_s_ready", 64'(bus.s_ready),   64'(1));
        rst = 1'b0;

        // Loopback and waveform
        push(24'hABCDEF, 24'h123456, 0);
        check("held_while_idle", 64'(bus.s_ready), 64'(0));
        bus.enable = 1'b1;
        wait_mvalid(2 * DIV + 4);
        t0 = cyc;
        check("first_load_underrun", 64'(bus.underrun), 64'(0));
        check("left_msb_on_bit1",    64'(bus.i2s_d_out), 64'(1));
        check("lr_left_slot",        64'(bus.i2s_lr),    64'(0));
        k = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            k += int'(bus.i2s_bclk);
        end
        check("bclk_duty",     64'(k),             64'(DIV));
        check("left_bit22",    64'(bus.i2s_d_out), 64'(0));
        wait_mvalid(FRAME_CLK + 4);
        check("m_valid_period", 64'(cyc - t0),     64'(512));
        check("loop_left",      64'(bus.m_left),   64'(24'hABCDEF));
        check("loop_right",     64'(bus.m_right),  64'(24'h123456));
        check("empty_underrun", 64'(bus.underrun), 64'(1));

        // Underrun over three frames
        #1;
        ur0 = ur_cnt; mv0 = mv_cnt; on0 = ones_cnt;
        repeat (3 * FRAME_CLK) @(negedge clk);
        #1;
        check("underrun_count", 64'(ur_cnt - ur0),   64'(3));
        check("m_valid_count",  64'(mv_cnt - mv0),   64'(3));
        check("silent_d_out",   64'(ones_cnt - on0), 64'(0));
        check("zero_frame",     64'(bus.m_left),     64'(0));

        // Backpressure with three samples offered back to back
        for (int i = 0; i < 3; i++) begin sl[i] = 24'($urandom); sr[i] = 24'($urandom); end
        base = mv_log.size();
        push(sl[0], sr[0], 1);
        check("bp_ready_low", 64'(bus.s_ready), 64'(0));
        push(sl[1], sr[1], 1);
        push(sl[2], sr[2], 0);
        wait_mvalid(FRAME_CLK + 4);
        wait_mvalid(FRAME_CLK + 4);
        #1;
        if (mv_log.size() < base + 4) fail_timeout("bp_log");
        else begin
            check("bp_gap",  64'(mv_log[base]),     64'(0));
            check("bp_s0",   64'(mv_log[base + 1]), 64'({sl[0], sr[0]}));
            check("bp_s1",   64'(mv_log[base + 2]), 64'({sl[1], sr[1]}));
            check("bp_s2",   64'(mv_log[base + 3]), 64'({sl[2], sr[2]}));
        end

        // Acceptance on the very load edge
        k = 0;
        while (!next_is_load() && k < 2 * FRAME_CLK) begin @(negedge clk); k++; end
        if (k == 2 * FRAME_CLK) fail_timeout("wait_load_edge");
        xl = 24'($urandom); xr = 24'($urandom);
        bus.s_left = xl; bus.s_right = xr; bus.s_valid = 1'b1;
        @(negedge clk);
        bus.s_valid = 1'b0;
        check("simul_underrun", 64'(bus.underrun), 64'(1));
        check("simul_kept",     64'(bus.s_ready),  64'(0));
        wait_mvalid(FRAME_CLK + 4);
        check("simul_zeros",    64'(bus.m_left),   64'(0));
        wait_mvalid(FRAME_CLK + 4);
        check("simul_left",     64'(bus.m_left),   64'(xl));
        check("simul_right",    64'(bus.m_right),  64'(xr));

        // Enable drop mid-frame, then re-enable
        wait_state(40);
        bus.enable = 1'b0;
        @(negedge clk);
        check("idle_bclk", 64'(bus.i2s_bclk),  64'(0));
        check("idle_lr",   64'(bus.i2s_lr),    64'(0));
        check("idle_dout", 64'(bus.i2s_d_out), 64'(0));
        #1;
        mv0 = mv_cnt;
        push(24'($urandom), 24'($urandom), 0);
        check("idle_accept", 64'(bus.s_ready), 64'(0));
        repeat (600) @(negedge clk);
        #1;
        check("idle_no_m_valid", 64'(mv_cnt - mv0), 64'(0));
        loopback = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;
        prev = bus.i2s_bclk;
        k = 0;
        for (int i = 1; i <= 4 * DIV; i++) begin
            @(negedge clk);
            if (k == 0 && prev && !bus.i2s_bclk) begin
                k = i;
                check("reenable_lr", 64'(bus.i2s_lr), 64'(0));
            end
            prev = bus.i2s_bclk;
        end
        check("reenable_fall", 64'(k), 64'(2 * DIV));

        // Random traffic against an independent slave, with one random enable gap
        stop_at  = $urandom_range(2 * FRAME_CLK, 5 * FRAME_CLK);
        stop_len = $urandom_range(10, 200);
        for (int i = 0; i < 8 * FRAME_CLK; i++) begin
            @(negedge clk);
            if (i == stop_at)            bus.enable = 1'b0;
            if (i == stop_at + stop_len) bus.enable = 1'b1;
            bus.s_valid = ($urandom_range(0, 999) < 3);
            bus.s_left  = 24'($urandom);
            bus.s_right = 24'($urandom);
        end
        bus.s_valid = 1'b0;

        // Asynchronous reset mid-frame with a full holding buffer
        wait_mvalid(FRAME_CLK + 4);
        push(24'($urandom), 24'($urandom), 0);
        wait_state(20);
        check("pre_rst_full", 64'(bus.s_ready), 64'(0));
        #2 rst = 1'b1;
        #1;
        check("arst_bclk",     64'(bus.i2s_bclk),  64'(0));
        check("arst_lr",       64'(bus.i2s_lr),    64'(0));
        check("arst_d_out",    64'(bus.i2s_d_out), 64'(0));
        check("arst_m_valid",  64'(bus.m_valid),   64'(0));
        check("arst_underrun", 64'(bus.underrun),  64'(0));
        check("arst_m_left",   64'(bus.m_left),    64'(0));
        check("arst_m_right",  64'(bus.m_right),   64'(0));
        check("arst_s_ready",  64'(bus.s_ready),   64'(1));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_mvalid(2 * DIV + 4);
        check("buffer_lost", 64'(bus.underrun), 64'(1));
        repeat (FRAME_CLK) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
